// File: rtl/uart_rx_byte_pkg.sv
// uart_rx_byte_pkg: shared UART state encodings, oversample indices and baud divider rounding.
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int OS_RATE = 16;
    localparam logic [3:0] S_SMP_A  = 4'd7;
    localparam logic [3:0] S_SMP_B  = 4'd8;
    localparam logic [3:0] S_DECIDE = 4'd9;
    localparam logic [3:0] S_LAST   = 4'd15;

    // Rounded clk cycles per oversample tick; the transmitter must use the same rounding.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + baud * os / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_byte_baud_tick.sv
// uart_baud_tick: one-clk tick every DIV clocks while en is high; held at phase 0 when disabled.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] DIV_M1 = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == DIV_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!en || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x oversampled 8N1 receiver with a one-entry valid/ready holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OS_RATE,
    parameter int DIV        = baud_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_wire,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_error,
    output logic       overrun,
    input  logic       overrun_clear,
    output logic       busy
);
    rx_state_t  state, state_n;
    logic       rx_m, rx_s;
    logic       tick;
    logic [3:0] s, s_nx;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       smp_a, smp_b;
    logic       maj, decide, last, done;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != IDLE),
        .tick (tick)
    );

    // A tick is numbered by the sample count it produces, so tick 9 lands 9 ticks into the bit.
    assign s_nx   = s + 4'd1;
    assign decide = tick && (s_nx == S_DECIDE);
    assign last   = tick && (s_nx == S_LAST);
    assign maj    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign done   = (state == STOP) && decide && maj;
    assign busy   = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = (decide && maj) ? IDLE : last ? DATA : START;
            DATA:    state_n = (last && bit_cnt == 3'd7) ? STOP : DATA;
            STOP:    state_n = decide ? (maj ? IDLE : BREAK) : STOP;
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            s           <= 4'd0;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            smp_a       <= 1'b0;
            smp_b       <= 1'b0;
            data        <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            rx_m        <= uart_rx_wire;
            rx_s        <= rx_m;
            s           <= (state == IDLE) ? 4'd0 : tick ? s_nx : s;
            smp_a       <= (tick && s_nx == S_SMP_A) ? rx_s : smp_a;
            smp_b       <= (tick && s_nx == S_SMP_B) ? rx_s : smp_b;
            bit_cnt     <= (state == START && last) ? 3'd0 :
                           (state == DATA && last) ? bit_cnt + 3'd1 : bit_cnt;
            shift       <= (state == DATA && decide) ? {maj, shift[7:1]} : shift;
            frame_error <= (state == STOP) && decide && !maj;
            // A byte landing while the consumer is accepting simply replaces the old one.
            if (done && (!data_valid || data_ready)) begin
                data       <= shift;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            overrun     <= (done && data_valid && !data_ready) || (overrun && !overrun_clear);
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames at DIV=10 (160 clk per bit) with hand-computed expectations.
module tb_uart_rx_byte;
    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart_rx_wire = 1'b1;
    logic       data_ready = 1'b0;
    logic       overrun_clear = 1'b0;
    logic [7:0] data;
    logic       data_valid, frame_error, overrun, busy;

    int errors = 0, checks = 0;
    int cyc_n = 0, fe_cnt = 0, t_start = 0, t_dv = 0;
    logic [7:0] acc_q[$];

    uart_rx_byte #(.CLK_HZ(1600000), .BAUD(10000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx_wire (uart_rx_wire),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .overrun_clear(overrun_clear),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (data_valid && data_ready) acc_q.push_back(data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int tail_low);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        cycles(1);
        t_start = cyc_n;
        for (int i = 0; i < 10; i++) begin
            uart_rx_wire = fr[i];
            cycles(BIT);
        end
        if (tail_low > 0) begin
            uart_rx_wire = 1'b0;
            cycles(tail_low);
        end
        uart_rx_wire = 1'b1;
    endtask

    task automatic wait_dv(input int max_cyc, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = data_valid;
        end
        t_dv = cyc_n;
    endtask

    task automatic drain();
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        int   fe0, rd;
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_fe", frame_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        cycles(5);
        rst_n = 1'b1;
        cycles(10);

        // Decision at 9*160+90 after the edge, plus 2 sync flops and 1 start-detect clk.
        fe0 = fe_cnt;
        rd  = acc_q.size();
        fork
            send_frame(8'hA5, 1'b1, 0);
            wait_dv(2000, seen);
        join
        check("t1_seen", seen, 1'b1);
        check("t1_latency", t_dv - t_start, 1533);
        check("t1_data", data, 8'hA5);
        check("t1_fe", fe_cnt - fe0, 0);
        check("t1_busy", busy, 1'b0);
        drain();
        check("t1_valid_clr", data_valid, 1'b0);
        check("t1_acc", acc_q[rd], 8'hA5);

        rd = acc_q.size();
        fork
            begin
                send_frame(8'h31, 1'b1, 0);
                send_frame(8'h2B, 1'b1, 0);
            end
            for (int k = 0; k < 2; k++) begin
                wait_dv(2000, seen);
                check("t2_seen", seen, 1'b1);
                cycles(1);
                drain();
            end
        join
        check("t2_count", acc_q.size() - rd, 2);
        check("t2_first", acc_q[rd], 8'h31);
        check("t2_second", acc_q[rd+1], 8'h2B);
        check("t2_ovr", overrun, 1'b0);
        check("t2_valid", data_valid, 1'b0);

        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        check("t3_data", data, 8'h01);
        check("t3_valid", data_valid, 1'b1);
        check("t3_ovr", overrun, 1'b1);
        overrun_clear = 1'b1;
        cycles(1);
        overrun_clear = 1'b0;
        check("t3_ovr_clr", overrun, 1'b0);
        rd = acc_q.size();
        drain();
        check("t3_acc", acc_q[rd], 8'h01);

        fe0 = fe_cnt;
        fork
            send_frame(8'h55, 1'b0, 3 * BIT);
            begin
                cycles(10 * BIT + 3 * BIT - 20);
                check("t4_busy_low", busy, 1'b1);
            end
        join
        cycles(5);
        check("t4_fe_count", fe_cnt - fe0, 1);
        check("t4_valid", data_valid, 1'b0);
        check("t4_busy_idle", busy, 1'b0);

        fe0 = fe_cnt;
        cycles(1);
        uart_rx_wire = 1'b0;
        cycles(40);
        uart_rx_wire = 1'b1;
        cycles(20);
        check("t5_busy_start", busy, 1'b1);
        cycles(60);
        check("t5_busy_idle", busy, 1'b0);
        check("t5_valid", data_valid, 1'b0);
        check("t5_fe", fe_cnt - fe0, 0);
        send_frame(8'h7E, 1'b1, 0);
        check("t5_data", data, 8'h7E);
        check("t5_dv", data_valid, 1'b1);

        rd = acc_q.size();
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                cycles(800);
                rst_n = 1'b0;
                #2;
                check("t6_rst_data", data, 8'h00);
                check("t6_rst_valid", data_valid, 1'b0);
                check("t6_rst_busy", busy, 1'b0);
                check("t6_rst_ovr", overrun, 1'b0);
                check("t6_rst_fe", frame_error, 1'b0);
                cycles(20);
                rst_n = 1'b1;
            end
        join
        check("t6_no_ff", data_valid, 1'b0);
        send_frame(8'h3C, 1'b1, 0);
        check("t6_data", data, 8'h3C);
        check("t6_valid", data_valid, 1'b1);
        check("t6_ovr", overrun, 1'b0);
        drain();
        check("t6_count", acc_q.size() - rd, 1);
        check("t6_acc", acc_q[rd], 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver for the calculator's UART RX path, sitting directly upstream of the calculator core.
- Oversamples the raw RX pin, recovers 8N1 frames and presents each byte on a valid/ready handshake.
- A one-entry holding register buffers the received byte.
- Reports framing errors and overruns so the core can flag bad input on its LEDs.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Fixed at 16; other values are unsupported.
- DIV, (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), Clk cycles per tick (derived, rounded). Default is 326.

Ports:
- Clk  in  1  system clock, rising edge.
- RstN  in  1  asynchronous active-low reset.
- UartRxWire  in  1  raw asynchronous RX pin; idles high.
- Data  out  8  received byte; stable while DataValid=1.
- DataValid  out  1  holding register full.
- DataReady  in  1  consumer accepts Data when DataValid&&DataReady.
- FrameError  out  1  one-Clk pulse on a bad stop bit.
- Overrun  out  1  sticky; a byte was dropped because the holding register was full.
- OverrunClear  in  1  synchronous clear of Overrun.
- Busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (RstN=0, async): FSM=IDLE; sync flops=1; tick counter, sample counter and bit counter=0.
  - Outputs: Data=8'h00, DataValid=0, FrameError=0, Overrun=0, Busy=0.
  - Reset mid-frame abandons the partial byte. After release the FSM requires a fresh falling edge.
- Input sync: 2-flop synchronizer on UartRxWire. All logic uses the synchronized value rx_s.
- Tick generator: counter 0..DIV-1, emits a one-Clk tick at DIV-1. It is held at 0 in IDLE and restarts at 0 on start detect, so bit timing is phase-aligned to the falling edge.
- Within each bit, a 4-bit sample counter s counts ticks 0..15.
  - rx_s is captured on ticks 7, 8 and 9.
  - The bit value is the 2-of-3 majority, decided on tick 9.
- FSM states:
  - IDLE: on rx_s=0, go to START with s=0.
  - START: at tick 9, majority=1 means a glitch or false start → IDLE with nothing reported. Majority=0 → continue; at tick 15 → DATA, bit counter=0.
  - DATA: at tick 9, shift the majority into the shift register, LSB first. At tick 15, increment the bit counter; after bit 7 → STOP.
  - STOP: at tick 9, majority=1 → byte complete → IDLE. Majority=0 → FrameError pulse, byte discarded → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. A held-low line produces exactly one FrameError.
- Return to IDLE at mid-stop-bit, not at the end of the stop bit. This tolerates up to ~half-bit clock mismatch and allows back-to-back frames.
- Holding register (latency: DataValid rises 1 Clk after the mid-stop decision):
  - Byte complete and DataValid=0 → load Data, DataValid=1.
  - Byte complete and DataValid&&DataReady in the same Clk → load the new byte, DataValid stays 1, no overrun.
  - Byte complete and DataValid=1, DataReady=0 → drop the new byte, keep the old one, set Overrun.
  - No completion and DataValid&&DataReady → DataValid=0; Data holds its last value.
- Overrun: OverrunClear in the same Clk as a new overrun leaves Overrun=1 (set wins).
- Busy=1 in START, DATA, STOP and BREAK.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, BREAK=3'd4;
  - OVERSAMPLE=16 and the sample indices 7, 8, 9, 15;
  - the DIV rounding macro, so the future uart_tx uses the same rounding.
- One sub-module, uart_baud_tick: parameter DIV; inputs Clk, RstN, En; output Tick. It is reused by the transmitter.

Test Plan:
Sim parameters: CLK_HZ=1600000, BAUD=10000, so DIV=10 and one bit = 160 Clk.
- Single frame 8'hA5 with DataReady=0 → DataValid rises 1 Clk after the stop-bit midpoint (bit 9 × 160 + 90 Clk after the start edge); Data=8'hA5; no FrameError; Busy low afterwards.
- Back-to-back frames 8'h31 then 8'h2B, DataReady pulsed 1 Clk after each DataValid → both bytes are delivered in order; Overrun=0.
- Two frames 8'h01, 8'h02 with DataReady=0 throughout → Data=8'h01, Overrun=1. Pulse OverrunClear → Overrun=0.
- Stop bit driven 0 on byte 8'h55, then line held low 3 bit times → exactly one FrameError pulse; DataValid stays 0; Busy=1 until the line returns high.
- Low glitch on the RX pin of 40 Clk → FSM returns to IDLE at the start-bit midpoint; no DataValid and no FrameError. A following valid 8'h7E is received correctly.
- Assert RstN=0 mid-DATA of 8'hFF, release it, then send 8'h3C → all outputs read their reset values during reset; only 8'h3C is delivered.
